// File: rtl/segasys1_wramarb.sv
// segasys1_wramarb: shares one single-port work RAM between the main CPU
// and a hiscore/host port. The CPU always wins; host accesses are fitted
// into the idle phases of each CPU clock-enable period so that they can
// never collide with a CPU slot.
//
// Ports
//   CLK40M, RESET          clock, synchronous active-high reset
//   CPU_EN                 one-cycle CPU clock-enable pulse every PERIOD cycles
//   CPU_CS/WR/AD/DI/DO     CPU work RAM select, strobe, address, data in/out
//   HS_REQ/WE/AD/DI        host request (level), write flag, address, data
//   HS_DO, HS_ACK          host read data (held), one-cycle completion pulse
//   RAM_AD/WE/D, RAM_Q     single-port RAM interface (RAM_Q one-cycle latency)
module segasys1_wramarb #(
    parameter int unsigned PERIOD = 8,
    parameter int unsigned AW     = 12
) (
    input  logic          CLK40M,
    input  logic          RESET,
    input  logic          CPU_EN,
    input  logic          CPU_CS,
    input  logic          CPU_WR,
    input  logic [AW-1:0] CPU_AD,
    input  logic [7:0]    CPU_DI,
    output logic [7:0]    CPU_DO,
    input  logic          HS_REQ,
    input  logic          HS_WE,
    input  logic [AW-1:0] HS_AD,
    input  logic [7:0]    HS_DI,
    output logic [7:0]    HS_DO,
    output logic          HS_ACK,
    output logic [AW-1:0] RAM_AD,
    output logic          RAM_WE,
    output logic [7:0]    RAM_D,
    input  logic [7:0]    RAM_Q
);

    localparam int unsigned PW = $clog2(PERIOD);
    localparam logic [PW-1:0] PH_MAX     = PW'(PERIOD - 1);
    // Last phase a host access may start and still finish its capture
    // cycle on the CPU_EN cycle, leaving the next cycle free for the CPU.
    localparam logic [PW-1:0] PH_HS_LAST = PW'(PERIOD - 3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CPU_ACC,
        S_CPU_CAP,
        S_HS_ACC,
        S_HS_CAP
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [7:0]      data_q,  data_d;
    logic            wr_q,    wr_d;
    logic            ram_we_q, ram_we_d;
    logic [7:0]      cpu_do_q, cpu_do_d;
    logic [7:0]      hs_do_q,  hs_do_d;
    logic            hs_ack_q, hs_ack_d;

    logic            cpu_start;
    logic            hs_start;

    // Next-state, latch and capture logic
    always_comb begin
        state_d  = S_IDLE;
        phase_d  = phase_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wr_d     = wr_q;
        ram_we_d = 1'b0;
        cpu_do_d = cpu_do_q;
        hs_do_d  = hs_do_q;
        hs_ack_d = 1'b0;

        // Phase restarts after every CPU_EN, selected or not
        if (CPU_EN) begin
            phase_d = '0;
        end else if (phase_q != PH_MAX) begin
            phase_d = phase_q + PW'(1);
        end

        // Capture cycles: RAM_Q now reflects the address driven last cycle
        if (state_q == S_CPU_CAP && !wr_q) begin
            cpu_do_d = RAM_Q;
        end
        if (state_q == S_HS_CAP) begin
            hs_ack_d = 1'b1;
            if (!wr_q) begin
                hs_do_d = RAM_Q;
            end
        end

        // A CPU slot may follow a host capture directly; a host start only from IDLE
        cpu_start = (state_q == S_IDLE || state_q == S_HS_CAP) && CPU_EN && CPU_CS;
        hs_start  = (state_q == S_IDLE) && HS_REQ && !CPU_EN && (phase_q <= PH_HS_LAST);

        if (cpu_start) begin
            state_d  = S_CPU_ACC;
            addr_d   = CPU_AD;
            data_d   = CPU_DI;
            wr_d     = CPU_WR;
            ram_we_d = CPU_WR;
        end else if (hs_start) begin
            state_d  = S_HS_ACC;
            addr_d   = HS_AD;
            data_d   = HS_DI;
            wr_d     = HS_WE;
            ram_we_d = HS_WE;
        end else begin
            case (state_q)
                S_CPU_ACC: state_d = S_CPU_CAP;
                S_HS_ACC:  state_d = S_HS_CAP;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge CLK40M) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            phase_q  <= PH_MAX;
            addr_q   <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
            ram_we_q <= 1'b0;
            cpu_do_q <= '0;
            hs_do_q  <= '0;
            hs_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            ram_we_q <= ram_we_d;
            cpu_do_q <= cpu_do_d;
            hs_do_q  <= hs_do_d;
            hs_ack_q <= hs_ack_d;
        end
    end

    // RAM address/data are the access latches, so they hold between accesses
    assign RAM_AD = addr_q;
    assign RAM_D  = data_q;
    assign RAM_WE = ram_we_q;
    assign CPU_DO = cpu_do_q;
    assign HS_DO  = hs_do_q;
    assign HS_ACK = hs_ack_q;

endmodule

// File: tb/tb_segasys1_wramarb.sv
// Bench for segasys1_wramarb: directed vector table, hand-written multi-cycle
// sequences and a randomized run, all cross-checked every cycle against an
// access-level reference model with its own shadow copy of the RAM.
module tb_segasys1_wramarb;

    localparam int P  = 8;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_en = 1'b0, cpu_cs = 1'b0, cpu_wr = 1'b0;
    logic [AW-1:0] cpu_ad = '0;
    logic [7:0]    cpu_di = '0;
    logic [7:0]    cpu_do;
    logic          hs_req = 1'b0, hs_we = 1'b0;
    logic [AW-1:0] hs_ad = '0;
    logic [7:0]    hs_di = '0;
    logic [7:0]    hs_do;
    logic          hs_ack;
    logic [AW-1:0] ram_ad;
    logic          ram_we;
    logic [7:0]    ram_d;
    logic [7:0]    ram_q = '0;

    int n_checks = 0;
    int n_err    = 0;

    segasys1_wramarb #(.PERIOD(P), .AW(AW)) dut (
        .CLK40M(clk), .RESET(rst),
        .CPU_EN(cpu_en), .CPU_CS(cpu_cs), .CPU_WR(cpu_wr),
        .CPU_AD(cpu_ad), .CPU_DI(cpu_di), .CPU_DO(cpu_do),
        .HS_REQ(hs_req), .HS_WE(hs_we), .HS_AD(hs_ad), .HS_DI(hs_di),
        .HS_DO(hs_do), .HS_ACK(hs_ack),
        .RAM_AD(ram_ad), .RAM_WE(ram_we), .RAM_D(ram_d), .RAM_Q(ram_q)
    );

    always #5 clk = ~clk;

    // Known initial RAM image, shared by the RAM model and the reference
    function automatic logic [7:0] init_val(int i);
        if (i == 'h123) return 8'h5A;
        if (i == 'h7FF) return 8'h99;
        if (i == 'h055) return 8'h66;
        return 8'(i * 37 + 11);
    endfunction

    // Single-port RAM with one-cycle registered read
    logic [7:0] mem [0:(1<<AW)-1];
    bit         ram_init;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= init_val(i);
            ram_init <= 1'b1;
        end else begin
            if (ram_we) mem[ram_ad] <= ram_d;
            ram_q <= mem[ram_ad];
        end
    end

    // ---------------- reference model ----------------
    // The model tracks the access in flight (owner + which of its two cycles)
    // and applies writes to a shadow RAM when they are issued; reads return
    // the shadow contents, since accesses never overlap.
    logic [7:0]    ref_mem [0:(1<<AW)-1];
    bit            m_valid = 0;
    int            m_phase, m_owner, m_cycle;  // owner: 0 none, 1 cpu, 2 host
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data, m_cdo, m_hdo;
    bit            m_wr, m_ack;

    task automatic model_step();
        bit was_hs_cap, was_free;
        if (rst) begin
            m_valid = 1; m_phase = P - 1; m_owner = 0; m_cycle = 0;
            m_addr = '0; m_data = '0; m_wr = 0; m_ack = 0; m_cdo = '0; m_hdo = '0;
            return;
        end
        if (!m_valid) return;
        was_hs_cap = (m_owner == 2 && m_cycle == 1);
        was_free   = (m_owner == 0) || was_hs_cap;
        m_ack = was_hs_cap;
        if (m_cycle == 1 && !m_wr && m_owner == 1) m_cdo = ref_mem[m_addr];
        if (was_hs_cap && !m_wr) m_hdo = ref_mem[m_addr];
        if (was_free && cpu_en && cpu_cs) begin
            m_owner = 1; m_cycle = 0; m_addr = cpu_ad; m_data = cpu_di; m_wr = cpu_wr;
        end else if (m_owner == 0 && hs_req && !cpu_en && m_phase <= P - 3) begin
            m_owner = 2; m_cycle = 0; m_addr = hs_ad; m_data = hs_di; m_wr = hs_we;
        end else if (m_owner != 0 && m_cycle == 0) begin
            m_cycle = 1;
        end else begin
            m_owner = 0; m_cycle = 0;
        end
        if (m_owner != 0 && m_cycle == 0 && m_wr) ref_mem[m_addr] = m_data;
        m_phase = cpu_en ? 0 : ((m_phase < P - 1) ? m_phase + 1 : P - 1);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        if (!m_valid) return;
        chk("model RAM_WE", 32'(ram_we), 32'(m_owner != 0 && m_cycle == 0 && m_wr));
        chk("model RAM_AD", 32'(ram_ad), 32'(m_addr));
        chk("model RAM_D",  32'(ram_d),  32'(m_data));
        chk("model HS_ACK", 32'(hs_ack), 32'(m_ack));
        chk("model HS_DO",  32'(hs_do),  32'(m_hdo));
        chk("model CPU_DO", 32'(cpu_do), 32'(m_cdo));
    endtask

    // One clock: inputs already driven; sample the result at the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_inputs();
        rst = 0; cpu_en = 0; cpu_cs = 0; cpu_wr = 0; cpu_ad = '0; cpu_di = '0;
        hs_req = 0; hs_we = 0; hs_ad = '0; hs_di = '0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit rst, en, cs, wr;
        logic [AW-1:0] ad; logic [7:0] di;
        bit req, hwe;
        logic [AW-1:0] had; logic [7:0] hdi;
        bit e_we; logic [AW-1:0] e_ad; logic [7:0] e_cdo; bit e_ack; logic [7:0] e_hdo;
    } vec_t;

    function automatic vec_t mk(bit r, bit en, bit cs, bit wr, int ad, int di,
                                bit req, bit hwe, int had, int hdi,
                                bit ewe, int ead, int ecdo, bit eack, int ehdo);
        vec_t v;
        v.rst = r; v.en = en; v.cs = cs; v.wr = wr; v.ad = AW'(ad); v.di = 8'(di);
        v.req = req; v.hwe = hwe; v.had = AW'(had); v.hdi = 8'(hdi);
        v.e_we = ewe; v.e_ad = AW'(ead); v.e_cdo = 8'(ecdo); v.e_ack = eack; v.e_hdo = 8'(ehdo);
        return v;
    endfunction

    vec_t vt [$];
    int   ack_cnt;
    int   en_cnt;

    initial begin
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_val(i);

        // Reset, CPU read of 0x123, CPU write of 0xC3 to 0x010
        vt.push_back(mk(1,0,0,0,0,0,     0,0,0,0,    0,'h000,'h00,0,'h00));
        vt.push_back(mk(0,1,1,0,'h123,0, 0,0,0,0,    0,'h123,'h00,0,'h00));
        vt.push_back(mk(0,0,0,0,0,0,     0,0,0,0,    0,'h123,'h00,0,'h00));
        for (int i = 0; i < 6; i++)
            vt.push_back(mk(0,0,0,0,0,0, 0,0,0,0,    0,'h123,'h5A,0,'h00));
        vt.push_back(mk(0,1,1,1,'h010,'hC3, 0,0,0,0, 1,'h010,'h5A,0,'h00));
        for (int i = 0; i < 5; i++)
            vt.push_back(mk(0,0,0,0,0,0, 0,0,0,0,    0,'h010,'h5A,0,'h00));
        // Host read raised at phase 5: ACC at 6, ACK on the phase-0 cycle
        vt.push_back(mk(0,0,0,0,0,0,     1,0,'h7FF,0, 0,'h7FF,'h5A,0,'h00));
        vt.push_back(mk(0,0,0,0,0,0,     1,0,'h7FF,0, 0,'h7FF,'h5A,0,'h00));
        vt.push_back(mk(0,1,0,0,0,0,     1,0,'h7FF,0, 0,'h7FF,'h5A,1,'h99));
        for (int i = 0; i < 6; i++)
            vt.push_back(mk(0,0,0,0,0,0, 0,0,0,0,    0,'h7FF,'h5A,0,'h99));
        // Host read raised at phase 6: blocked through CPU_EN, starts at phase 0
        vt.push_back(mk(0,0,0,0,0,0,     1,0,'h055,0, 0,'h7FF,'h5A,0,'h99));
        vt.push_back(mk(0,1,0,0,0,0,     1,0,'h055,0, 0,'h7FF,'h5A,0,'h99));
        vt.push_back(mk(0,0,0,0,0,0,     1,0,'h055,0, 0,'h055,'h5A,0,'h99));
        // Inputs changed after the latch point must not matter
        vt.push_back(mk(0,0,0,0,0,0,     0,1,'h3AA,'hEE, 0,'h055,'h5A,0,'h99));
        vt.push_back(mk(0,0,0,0,0,0,     0,0,0,0,    0,'h055,'h5A,1,'h66));

        @(negedge clk);
        foreach (vt[k]) begin
            rst = vt[k].rst; cpu_en = vt[k].en; cpu_cs = vt[k].cs; cpu_wr = vt[k].wr;
            cpu_ad = vt[k].ad; cpu_di = vt[k].di; hs_req = vt[k].req; hs_we = vt[k].hwe;
            hs_ad = vt[k].had; hs_di = vt[k].hdi;
            tick();
            chk($sformatf("vec%0d RAM_WE", k), 32'(ram_we), 32'(vt[k].e_we));
            chk($sformatf("vec%0d RAM_AD", k), 32'(ram_ad), 32'(vt[k].e_ad));
            chk($sformatf("vec%0d CPU_DO", k), 32'(cpu_do), 32'(vt[k].e_cdo));
            chk($sformatf("vec%0d HS_ACK", k), 32'(hs_ack), 32'(vt[k].e_ack));
            chk($sformatf("vec%0d HS_DO",  k), 32'(hs_do),  32'(vt[k].e_hdo));
        end

        // Back-to-back host writes, new address presented on each ACK
        idle_inputs(); cpu_en = 1; tick();
        idle_inputs(); hs_req = 1; hs_we = 1; hs_ad = 'h001; hs_di = 'hA1;
        tick();
        chk("b2b first WE", 32'(ram_we), 32'd1);
        chk("b2b first AD", 32'(ram_ad), 32'h001);
        tick(); tick();
        chk("b2b first ACK", 32'(hs_ack), 32'd1);
        hs_ad = 'h002; hs_di = 'hA2;
        tick();
        chk("b2b second WE", 32'(ram_we), 32'd1);
        chk("b2b second AD", 32'(ram_ad), 32'h002);
        chk("b2b second D",  32'(ram_d),  32'hA2);
        tick(); tick();
        chk("b2b second ACK", 32'(hs_ack), 32'd1);
        hs_req = 0;
        tick();
        chk("b2b no third start", 32'(ram_we), 32'd0);
        chk("b2b mem 001", 32'(mem['h001]), 32'hA1);
        chk("b2b mem 002", 32'(mem['h002]), 32'hA2);

        // Reset during a host write access aborts it
        idle_inputs(); cpu_en = 1; tick();
        idle_inputs(); hs_req = 1; hs_we = 1; hs_ad = 'h020; hs_di = 'h11;
        tick();
        chk("rst-mid HS_ACC WE", 32'(ram_we), 32'd1);
        chk("rst-mid HS_ACC AD", 32'(ram_ad), 32'h020);
        rst = 1; hs_req = 0;
        tick();
        chk("rst-mid WE",  32'(ram_we), 32'd0);
        chk("rst-mid AD",  32'(ram_ad), 32'd0);
        chk("rst-mid D",   32'(ram_d),  32'd0);
        chk("rst-mid ACK", 32'(hs_ack), 32'd0);
        chk("rst-mid CDO", 32'(cpu_do), 32'd0);
        chk("rst-mid HDO", 32'(hs_do),  32'd0);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst-mid no ACK after", 32'(hs_ack), 32'd0);
        end

        // Collision: host requesting continuously, CPU read every period
        for (int k = 0; k < 5; k++) begin
            ack_cnt = 0;
            for (int c = 0; c < P; c++) begin
                idle_inputs(); hs_req = 1; hs_ad = AW'($urandom);
                if (c == 0) begin cpu_en = 1; cpu_cs = 1; cpu_ad = AW'('h100 + k); end
                tick();
                if (c == 0 && k > 0) chk("collide CPU slot AD", 32'(ram_ad), 32'('h100 + k));
                if (ram_we) chk("collide WE on reads", 32'(ram_we), 32'd0);
                if (hs_ack) ack_cnt++;
            end
            if (k > 0) chk("collide ACKs per period", 32'(ack_cnt), 32'd2);
        end

        // Randomized traffic against the reference model
        en_cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            rst    = ($urandom_range(0, 150) == 0);
            cpu_en = (en_cnt == P - 1);
            en_cnt = (en_cnt == P - 1) ? 0 : en_cnt + 1;
            cpu_cs = $urandom_range(0, 3) != 0;
            cpu_wr = $urandom_range(0, 1) != 0;
            cpu_ad = AW'($urandom_range(0, 63));
            cpu_di = 8'($urandom);
            hs_req = $urandom_range(0, 2) != 0;
            hs_we  = $urandom_range(0, 1) != 0;
            hs_ad  = AW'($urandom_range(0, 63));
            hs_di  = 8'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
